// File: rtl/inf_seq.sv
// inf_seq: streams NIN input words into a core register file, pulses the
// core start, waits for core_ready (bounded by TIMEOUT), then reads NOUT
// result words back out over a valid/ready stream.
module inf_seq #(
  parameter int unsigned DEPTH    = 5,
  parameter int unsigned NIN      = 4,
  parameter int unsigned NOUT     = 4,
  parameter int unsigned IN_BASE  = 0,
  parameter int unsigned OUT_BASE = 16,
  parameter int unsigned TIMEOUT  = 1024
) (
  input  logic             clk_i,
  input  logic             rst,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [31:0]      s_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [31:0]      m_data,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic             core_start,
  input  logic             core_ready,
  output logic             core_we,
  output logic [DEPTH-1:0] core_addr,
  output logic [31:0]      core_wdata,
  input  logic [31:0]      core_rdata
);

  localparam int unsigned WCW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  localparam logic [DEPTH-1:0] LAST_IN    = DEPTH'(NIN - 1);
  localparam logic [DEPTH-1:0] LAST_OUT   = DEPTH'(NOUT - 1);
  localparam logic [DEPTH-1:0] IN_BASE_A  = DEPTH'(IN_BASE);
  localparam logic [DEPTH-1:0] OUT_BASE_A = DEPTH'(OUT_BASE);
  localparam logic [WCW-1:0]   WAIT_LAST  = WCW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE, LOAD, START, WAIT, RD_ADDR, RD_CAP, OUT, DONE
  } state_t;

  state_t           state_q, state_d;
  logic [DEPTH-1:0] load_cnt_q, load_cnt_d;
  logic [DEPTH-1:0] out_cnt_q, out_cnt_d;
  logic [WCW-1:0]   wait_cnt_q, wait_cnt_d;
  logic             err_q, err_d;
  logic             m_valid_q, m_valid_d;
  logic [31:0]      m_data_q, m_data_d;
  logic             busy_q, done_q, start_q;
  logic             beat;

  assign s_ready    = (state_q == IDLE) || (state_q == LOAD);
  assign beat       = s_valid && s_ready;
  assign m_valid    = m_valid_q;
  assign m_data     = m_data_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign err        = err_q;
  assign core_start = start_q;

  // Core port: write on an input beat, read address in RD_ADDR, else zero.
  always_comb begin
    core_we    = beat;
    core_wdata = s_data;
    core_addr  = '0;
    if (beat) begin
      core_addr = IN_BASE_A + load_cnt_q;
    end else if (state_q == RD_ADDR) begin
      core_addr = OUT_BASE_A + out_cnt_q;
    end
  end

  // Next-state and counter/output updates for the sequencer.
  always_comb begin
    state_d    = state_q;
    load_cnt_d = load_cnt_q;
    out_cnt_d  = out_cnt_q;
    wait_cnt_d = wait_cnt_q;
    err_d      = err_q;
    m_valid_d  = m_valid_q;
    m_data_d   = m_data_q;
    case (state_q)
      IDLE: begin
        load_cnt_d = '0;
        if (beat) begin
          err_d = 1'b0;
          if (NIN == 1) begin
            state_d = START;
          end else begin
            load_cnt_d = DEPTH'(1);
            state_d    = LOAD;
          end
        end
      end
      LOAD: begin
        if (beat) begin
          if (load_cnt_q == LAST_IN) begin
            load_cnt_d = '0;
            state_d    = START;
          end else begin
            load_cnt_d = load_cnt_q + DEPTH'(1);
          end
        end
      end
      START: begin
        wait_cnt_d = '0;
        state_d    = WAIT;
      end
      WAIT: begin
        if (core_ready) begin
          out_cnt_d = '0;
          state_d   = RD_ADDR;
        end else if (wait_cnt_q == WAIT_LAST) begin
          err_d   = 1'b1;
          state_d = DONE;
        end else begin
          wait_cnt_d = wait_cnt_q + WCW'(1);
        end
      end
      RD_ADDR: state_d = RD_CAP;
      RD_CAP: begin
        m_data_d  = core_rdata;
        m_valid_d = 1'b1;
        state_d   = OUT;
      end
      OUT: begin
        if (m_ready) begin
          m_valid_d = 1'b0;
          if (out_cnt_q == LAST_OUT) begin
            state_d = DONE;
          end else begin
            out_cnt_d = out_cnt_q + DEPTH'(1);
            state_d   = RD_ADDR;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register; busy/done/core_start are registered from the next state
  // so they line up exactly with the state they describe.
  always_ff @(posedge clk_i) begin
    if (rst) begin
      state_q    <= IDLE;
      load_cnt_q <= '0;
      out_cnt_q  <= '0;
      wait_cnt_q <= '0;
      err_q      <= 1'b0;
      m_valid_q  <= 1'b0;
      m_data_q   <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      start_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      load_cnt_q <= load_cnt_d;
      out_cnt_q  <= out_cnt_d;
      wait_cnt_q <= wait_cnt_d;
      err_q      <= err_d;
      m_valid_q  <= m_valid_d;
      m_data_q   <= m_data_d;
      busy_q     <= (state_d != IDLE);
      done_q     <= (state_d == DONE);
      start_q    <= (state_d == START);
    end
  end

endmodule

// File: tb/tb_inf_seq.sv
// tb_inf_seq: randomized operations against a behavioural core model and a
// transaction-level expectation of the write/readback streams.
`timescale 1ns/1ps
module tb_inf_seq;

  localparam int unsigned TMO = 1024;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // sel=0 exercises the default instance, sel=1 the single-word instance
  logic        sel;
  logic        s_valid, m_ready;
  logic [31:0] s_data;
  int unsigned cr_mode, cr_delay;   // core behaviour: 0 pulse, 1 stuck low, 2 held high
  logic [31:0] cr_key;

  logic        a_s_valid, a_s_ready, a_m_valid, a_m_ready, a_busy, a_done, a_err;
  logic        a_core_start, a_core_ready, a_core_we;
  logic [31:0] a_m_data, a_core_wdata, a_core_rdata;
  logic [4:0]  a_core_addr;
  logic        b_s_valid, b_s_ready, b_m_valid, b_m_ready, b_busy, b_done, b_err;
  logic        b_core_start, b_core_ready, b_core_we;
  logic [31:0] b_m_data, b_core_wdata, b_core_rdata;
  logic [4:0]  b_core_addr;

  assign a_s_valid = s_valid & ~sel;
  assign b_s_valid = s_valid & sel;
  assign a_m_ready = m_ready & ~sel;
  assign b_m_ready = m_ready & sel;

  logic        o_s_ready, o_m_valid, o_busy, o_done, o_err, o_core_start, o_core_we;
  logic [31:0] o_m_data, o_core_wdata;
  logic [4:0]  o_core_addr;
  assign o_s_ready    = sel ? b_s_ready    : a_s_ready;
  assign o_m_valid    = sel ? b_m_valid    : a_m_valid;
  assign o_m_data     = sel ? b_m_data     : a_m_data;
  assign o_busy       = sel ? b_busy       : a_busy;
  assign o_done       = sel ? b_done       : a_done;
  assign o_err        = sel ? b_err        : a_err;
  assign o_core_start = sel ? b_core_start : a_core_start;
  assign o_core_we    = sel ? b_core_we    : a_core_we;
  assign o_core_addr  = sel ? b_core_addr  : a_core_addr;
  assign o_core_wdata = sel ? b_core_wdata : a_core_wdata;

  inf_seq u_dut_a (
    .clk_i(clk), .rst(rst),
    .s_valid(a_s_valid), .s_ready(a_s_ready), .s_data(s_data),
    .m_valid(a_m_valid), .m_ready(a_m_ready), .m_data(a_m_data),
    .busy(a_busy), .done(a_done), .err(a_err),
    .core_start(a_core_start), .core_ready(a_core_ready),
    .core_we(a_core_we), .core_addr(a_core_addr),
    .core_wdata(a_core_wdata), .core_rdata(a_core_rdata)
  );

  inf_seq #(
    .DEPTH(5), .NIN(1), .NOUT(1), .IN_BASE(31), .OUT_BASE(31), .TIMEOUT(TMO)
  ) u_dut_b (
    .clk_i(clk), .rst(rst),
    .s_valid(b_s_valid), .s_ready(b_s_ready), .s_data(s_data),
    .m_valid(b_m_valid), .m_ready(b_m_ready), .m_data(b_m_data),
    .busy(b_busy), .done(b_done), .err(b_err),
    .core_start(b_core_start), .core_ready(b_core_ready),
    .core_we(b_core_we), .core_addr(b_core_addr),
    .core_wdata(b_core_wdata), .core_rdata(b_core_rdata)
  );

  // Core model A: result k = key + input word (k mod 4), stored at 16+k.
  logic [31:0] a_mem [32];
  int unsigned a_cd;
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) a_mem[i] <= '0;
      a_core_rdata <= '0;
      a_core_ready <= 1'b0;
      a_cd         <= 0;
    end else begin
      if (a_core_we) a_mem[a_core_addr] <= a_core_wdata;
      a_core_rdata <= a_mem[a_core_addr];
      if (a_core_start) begin
        for (int k = 0; k < 4; k++) a_mem[5'(16 + k)] <= cr_key + a_mem[5'(k)];
        a_cd <= cr_delay;
      end else if (a_cd != 0) begin
        a_cd <= a_cd - 1;
      end
      a_core_ready <= (cr_mode == 2) || (cr_mode == 0 && !a_core_start && a_cd == 1);
    end
  end

  // Core model B: single word at address 31, result = key + input.
  logic [31:0] b_mem [32];
  int unsigned b_cd;
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) b_mem[i] <= '0;
      b_core_rdata <= '0;
      b_core_ready <= 1'b0;
      b_cd         <= 0;
    end else begin
      if (b_core_we) b_mem[b_core_addr] <= b_core_wdata;
      b_core_rdata <= b_mem[b_core_addr];
      if (b_core_start) begin
        b_mem[31] <= cr_key + b_mem[31];
        b_cd      <= cr_delay;
      end else if (b_cd != 0) begin
        b_cd <= b_cd - 1;
      end
      b_core_ready <= (cr_mode == 2) || (cr_mode == 0 && !b_core_start && b_cd == 1);
    end
  end

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  logic [31:0] words [4];
  logic        last_err;

  // One operation, driven and observed cycle by cycle starting at a negedge.
  // rst_pt: 0 none, 1 reset on the 2nd input beat, 2 reset while m_valid=1.
  task automatic run_op(input int unsigned gap, input int unsigned stall, input int unsigned mode,
                        input int unsigned delay, input int unsigned rst_pt, input bit directed);
    int unsigned nin, nout, inb;
    logic [31:0] exp [4];
    logic [31:0] hold_data;
    int unsigned sent, got, gapc, stallc, cyc, cs, cm, last_hs, n_start;
    bit done_seen, first_m, aborted, clr_pending, holding;
    logic beat;
    nin  = sel ? 1 : 4;
    nout = sel ? 1 : 4;
    inb  = sel ? 31 : 0;
    cr_mode  = mode;
    cr_delay = delay;
    if (directed) begin
      for (int i = 0; i < 4; i++) words[i] = 32'hA0 + 32'(i);
      cr_key = 32'hFFFF_FF70;
    end else begin
      for (int i = 0; i < 4; i++) words[i] = $urandom;
      cr_key = $urandom;
    end
    for (int k = 0; k < 4; k++) exp[k] = cr_key + words[k % nin];
    check("err_hold", 32'(o_err), 32'(last_err));
    sent = 0; got = 0; gapc = gap; stallc = stall; cyc = 0; cs = 0; cm = 0;
    last_hs = 0; n_start = 0; hold_data = '0;
    done_seen = 0; first_m = 0; aborted = 0; clr_pending = 0; holding = 0;
    while (!done_seen && !aborted && cyc < 2000) begin
      if (sent < nin && gapc == 0) begin
        s_valid = 1'b1;
        s_data  = words[sent];
      end else begin
        s_valid = 1'b0;
        s_data  = $urandom;
        if (sent < nin && gapc > 0) gapc--;
      end
      if (o_m_valid && stallc > 0) begin
        m_ready = 1'b0;
        stallc--;
      end else if (o_m_valid) begin
        m_ready = 1'b1;
      end else begin
        m_ready = 1'($urandom_range(0, 1));
      end
      if ((rst_pt == 1 && s_valid && sent == 1) || (rst_pt == 2 && o_m_valid)) rst = 1'b1;
      #1;
      if (rst) begin
        @(negedge clk);
        rst = 1'b0; s_valid = 1'b0; m_ready = 1'b0;
        #1;
        check("rst_busy", 32'(o_busy), 32'd0);
        check("rst_m_valid", 32'(o_m_valid), 32'd0);
        check("rst_done", 32'(o_done), 32'd0);
        check("rst_err", 32'(o_err), 32'd0);
        check("rst_s_ready", 32'(o_s_ready), 32'd1);
        check("rst_m_data", o_m_data, 32'd0);
        aborted  = 1;
        last_err = 1'b0;
      end else begin
        if (clr_pending) begin
          check("err_clr", 32'(o_err), 32'd0);
          clr_pending = 0;
        end
        beat = s_valid && o_s_ready;
        check("core_we", 32'(o_core_we), 32'(beat));
        if (beat) begin
          check("wr_addr", 32'(o_core_addr), 32'((inb + sent) % 32));
          check("wr_data", o_core_wdata, words[sent]);
          sent++;
          gapc = gap;
          if (sent == 1) clr_pending = 1;
        end else if (!o_busy) begin
          check("idle_addr", 32'(o_core_addr), 32'd0);
        end
        if (o_core_start) begin
          n_start++;
          cs = cyc;
        end
        if (o_m_valid) begin
          if (!first_m) begin
            first_m = 1;
            cm = cyc;
          end
          if (holding) check("m_stable", o_m_data, hold_data);
          if (m_ready) begin
            if (got < nout) check("m_data", o_m_data, exp[got]);
            else check("m_extra", got + 1, nout);
            if (stall == 0 && got > 0) check("rate", cyc - last_hs, 32'd3);
            last_hs = cyc;
            got++;
            stallc  = stall;
            holding = 0;
          end else begin
            holding   = 1;
            hold_data = o_m_data;
          end
        end
        if (o_done) begin
          done_seen = 1;
          check("err", 32'(o_err), 32'(mode == 1));
          check("n_in", sent, nin);
          check("n_out", got, (mode == 1) ? 0 : nout);
          check("n_start", n_start, 32'd1);
          if (mode == 1) check("wait_len", cyc - cs, TMO + 1);
          if (mode == 2) check("ready_lat", cm - cs, 32'd4);
          last_err = (mode == 1);
        end
      end
      if (!aborted) begin
        @(negedge clk);
        cyc++;
      end
    end
    if (!aborted) begin
      check("op_done", 32'(done_seen), 32'd1);
      s_valid = 1'b0;
      #1;
      check("done_pulse", 32'(o_done), 32'd0);
      check("end_busy", 32'(o_busy), 32'd0);
      check("end_m_valid", 32'(o_m_valid), 32'd0);
    end
  endtask

  initial begin
    sel = 1'b0; s_valid = 1'b0; s_data = '0; m_ready = 1'b0;
    cr_mode = 0; cr_delay = 3; cr_key = '0; last_err = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check("reset_busy", 32'(o_busy), 32'd0);
    check("reset_m_valid", 32'(o_m_valid), 32'd0);
    check("reset_done", 32'(o_done), 32'd0);
    check("reset_err", 32'(o_err), 32'd0);
    check("reset_start", 32'(o_core_start), 32'd0);
    check("reset_m_data", o_m_data, 32'd0);
    check("reset_s_ready", 32'(o_s_ready), 32'd1);
    check("reset_we", 32'(o_core_we), 32'd0);
    check("reset_addr", 32'(o_core_addr), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    run_op(0, 0, 0, 5, 0, 1);   // directed A0..A3 -> 0x10..0x13
    run_op(2, 3, 0, 4, 0, 0);   // input gaps and output stalls
    run_op(0, 0, 1, 0, 0, 0);   // core never ready
    run_op(0, 0, 0, 2, 0, 0);   // err held then cleared by first beat
    run_op(0, 0, 2, 0, 0, 0);   // core_ready already high
    run_op(0, 0, 0, 3, 1, 0);   // reset mid-load
    run_op(0, 0, 0, 3, 2, 0);   // reset with m_valid high
    run_op(0, 0, 0, 3, 0, 0);   // fresh operation after reset
    for (int i = 0; i < 6; i++)
      run_op($urandom_range(0, 3), $urandom_range(0, 3), ($urandom_range(0, 1) == 0) ? 0 : 2,
             $urandom_range(1, 8), 0, 0);

    sel = 1'b1;
    run_op(0, 0, 0, 3, 0, 0);
    run_op(1, 2, 2, 0, 0, 0);
    run_op($urandom_range(0, 3), $urandom_range(0, 3), 0, $urandom_range(1, 8), 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/inf_seq.md
INF_SEQ -- requirements
Module: inf_seq

Interface
REQ-001 The block SHALL have parameter DEPTH, default 5, core register-file address width (2^DEPTH words).
REQ-002 The block SHALL have parameter NIN, default 4, number of input words loaded per operation (1..2^DEPTH).
REQ-003 The block SHALL have parameter NOUT, default 4, number of result words read back per operation (1..2^DEPTH).
REQ-004 The block SHALL have parameter IN_BASE, default 0, core address of input word 0.
REQ-005 The block SHALL have parameter OUT_BASE, default 16, core address of result word 0.
REQ-006 The block SHALL have parameter TIMEOUT, default 1024, maximum number of WAIT cycles (>=2).
REQ-007 The block SHALL have one clock and a synchronous, active-high reset, with the ports below.
REQ-008 clk_i  in  1  sole clock; all state updates on its rising edge.
REQ-009 rst  in  1  synchronous active-high reset.
REQ-010 s_valid  in  1 / s_ready  out  1 / s_data  in  32: input word stream.
REQ-011 m_valid  out  1 / m_ready  in  1 / m_data  out  32: result word stream.
REQ-012 busy  out  1  high in every state except IDLE.
REQ-013 done  out  1  one-cycle pulse at the end of each operation.
REQ-014 err  out  1  timeout flag for the last operation.
REQ-015 core_start  out  1 / core_ready  in  1: start/ready handshake with the downstream core.
REQ-016 core_we  out  1 / core_addr  out  DEPTH / core_wdata  out  32 / core_rdata  in  32: core register-file port; core_rdata is registered in the core, valid the cycle after core_addr is presented.

Function
REQ-017 The FSM SHALL have states IDLE, LOAD, START, WAIT, RD_ADDR, RD_CAP, OUT, DONE.
REQ-018 s_ready SHALL be 1 in IDLE and LOAD and 0 in all other states; a beat SHALL transfer when s_valid && s_ready.
REQ-019 On a beat, core_we SHALL be 1 combinationally in that cycle, with core_wdata=s_data and core_addr=IN_BASE+load_cnt (mod 2^DEPTH); core_we SHALL be 0 at all other times.
REQ-020 load_cnt SHALL be 0 in IDLE and increment per beat; a beat in IDLE SHALL be word 0, clear err, and go to LOAD (or to START if NIN==1).
REQ-021 In LOAD, the beat with load_cnt==NIN-1 SHALL transition to START; LOAD SHALL wait indefinitely with s_valid low.
REQ-022 core_start SHALL be 1 for exactly the single START cycle; START SHALL always go to WAIT.
REQ-023 In WAIT, core_ready sampled 1 SHALL go to RD_ADDR with out_cnt=0; core_ready is ignored in every other state, including START.
REQ-024 wait_cnt SHALL count WAIT cycles from 0; if core_ready is still 0 when wait_cnt==TIMEOUT-1, err SHALL be set to 1 and the FSM SHALL go to DONE, skipping readback.
REQ-025 RD_ADDR SHALL drive core_addr=OUT_BASE+out_cnt with core_we=0 for one cycle and then go to RD_CAP.
REQ-026 In RD_CAP, core_rdata SHALL be registered into m_data, m_valid SHALL be set on the next edge, and the FSM SHALL go to OUT.
REQ-027 In OUT, m_valid and m_data SHALL hold stable until m_ready; on handshake, m_valid SHALL drop and the FSM SHALL go to DONE if out_cnt==NOUT-1, else increment out_cnt and go to RD_ADDR.
REQ-028 The minimum readback rate SHALL be one word per 3 cycles.
REQ-029 DONE SHALL assert done for one cycle and return to IDLE; err SHALL hold until the next IDLE beat.
REQ-030 When not otherwise driven, core_addr SHALL be 0.

Reset
REQ-031 A rst sampled high SHALL force IDLE in any state, including mid-LOAD, mid-WAIT, and OUT with m_valid high.
REQ-032 Reset SHALL clear load_cnt, out_cnt, wait_cnt, and err, set m_data=0, and drive m_valid=0, done=0, busy=0, core_start=0, core_we=0 from the next cycle.
REQ-033 rst SHALL be shared with the core so that the core register file is cleared at the same time.

Verification
REQ-034 Stream 4 words A0..A3, core_ready pulsed 5 cycles after core_start, results 0x10..0x13 at core addrs 16..19 -> writes at addrs 0..3 in order; m_data=0x10,0x11,0x12,0x13; done pulses once; err=0.
REQ-035 s_valid gaps of 2 cycles between beats and m_ready low for 3 cycles per result -> identical data; no duplicate or lost words; m_data stable while stalled.
REQ-036 core_ready stuck at 0 -> exactly 1024 WAIT cycles, then err=1 and a done pulse, with no m_valid; the next operation's first beat clears err.
REQ-037 core_ready held 1 before start -> core_start is a single one-cycle pulse; WAIT exits on its first cycle; readback is correct.
REQ-038 rst asserted at the 2nd LOAD beat and again while m_valid=1 -> the next cycle shows IDLE with busy=0, m_valid=0; a fresh operation then completes correctly.
REQ-039 NIN=1, NOUT=1, IN_BASE=31, OUT_BASE=31 -> a single write to addr 31; readback returns the core's value at addr 31; done pulses.
